// File: rtl/neopixel_pkg.sv
// neopixel_pkg: timing constants shared with the neopixel transmitter and the
// receiver state encoding.
package neopixel_pkg;

  // Nominal transmitter timing in 20 MHz clock cycles
  localparam int T_BIT   = 25;
  localparam int T0H     = 6;
  localparam int T1H     = 12;
  localparam int T_LATCH = 1600;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

endpackage

// File: rtl/neopixel_sync.sv
// neopixel_sync: brings the asynchronous serial line into the clk domain with a
// 2-FF synchroniser and produces single-cycle rise/fall strobes from it.
module neopixel_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchroniser chain and the one-cycle delayed copy
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign din_s = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/neopixel_rx.sv
// neopixel_rx: WS2812-style single-wire decoder. Classifies high pulses by width,
// assembles bytes MSB-first, reports byte index within the frame and flags the
// frame end on the latch gap. Optional forwarding of the line past this pixel's
// own bytes is enabled with the macro NEOPIXEL_RX_FWD_EN.
module neopixel_rx
  import neopixel_pkg::*;
#(
  parameter int HIGH_MIN     = 3,
  parameter int T1_MIN       = 9,
  parameter int HIGH_MAX     = 20,
  parameter int LATCH_CYCLES = 800,
  parameter int OWN_BYTES    = 3
) (
  input  logic       clk_20M,
  input  logic       nrst,
  input  logic       din,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [5:0] byte_index,
  output logic       frame_done,
  output logic [5:0] frame_bytes,
  output logic       bit_err,
  output logic       dout
);

  localparam int HW = $clog2(HIGH_MAX + 2);
  localparam logic [HW-1:0] HI_MIN_C = HW'(HIGH_MIN);
  localparam logic [HW-1:0] T1_C     = HW'(T1_MIN);
  localparam logic [HW-1:0] HI_MAX_C = HW'(HIGH_MAX);
  localparam logic [HW-1:0] HI_SAT_C = HW'(HIGH_MAX + 1);
  localparam logic [10:0]   LATCH_C  = 11'(LATCH_CYCLES);

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  logic            rst_meta_q, rst_n_q;
  logic            din_s, rise, fall;
  rx_state_t       state_q, state_d;
  logic [HW-1:0]   hi_cnt_q, hi_cnt_d;
  logic [10:0]     lo_cnt_q, lo_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [5:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            byte_valid_q, byte_valid_d;
  logic [5:0]      byte_index_q, byte_index_d;
  logic            frame_done_q, frame_done_d;
  logic [5:0]      frame_bytes_q, frame_bytes_d;
  logic            bit_err_q, bit_err_d;
  logic            latch;
  logic            bit_val;
`ifdef NEOPIXEL_RX_FWD_EN
  localparam logic [5:0] OWN_LAST_C = 6'(OWN_BYTES - 1);
  logic fwd_active_q, fwd_active_d;
  logic dout_q, dout_d;
`endif

  // Reset synchroniser: asserts immediately, releases on a clock edge
  always_ff @(posedge clk_20M or negedge nrst) begin
    if (!nrst) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  neopixel_sync u_sync (
    .clk   (clk_20M),
    .rst_n (rst_n_q),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign latch   = (lo_cnt_q == LATCH_C);
  assign bit_val = (hi_cnt_q >= T1_C);

  // Pulse-width counters, next state, byte assembly and output strobes
  always_comb begin
    hi_cnt_d      = din_s ? ((hi_cnt_q == HI_SAT_C) ? hi_cnt_q : hi_cnt_q + 1'b1) : '0;
    lo_cnt_d      = din_s ? 11'd0 : (latch ? lo_cnt_q : lo_cnt_q + 11'd1);
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    byte_index_d  = byte_index_q;
    frame_done_d  = 1'b0;
    frame_bytes_d = frame_bytes_q;
    bit_err_d     = 1'b0;
`ifdef NEOPIXEL_RX_FWD_EN
    fwd_active_d  = fwd_active_q;
    dout_d        = din_s & fwd_active_q;
`endif
    unique case (state_q)
      SYNC_WAIT: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 6'd0;
        if (latch) state_d = rise ? HIGH : IDLE;
      end
      IDLE: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 6'd0;
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        // A pulse stuck high past the limit, or a falling edge with an illegal width
        if ((din_s && hi_cnt_q == HI_SAT_C) ||
            (fall && (hi_cnt_q < HI_MIN_C || hi_cnt_q > HI_MAX_C))) begin
          bit_err_d  = 1'b1;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 6'd0;
          state_d    = SYNC_WAIT;
`ifdef NEOPIXEL_RX_FWD_EN
          fwd_active_d = 1'b0;
`endif
        end else if (fall) begin
          shift_d   = {shift_q[6:0], bit_val};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = LOW;
          if (bit_cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shift_q[6:0], bit_val};
            byte_index_d = byte_cnt_q;
            byte_cnt_d   = sat_inc6(byte_cnt_q);
`ifdef NEOPIXEL_RX_FWD_EN
            if (byte_cnt_q == OWN_LAST_C) fwd_active_d = 1'b1;
`endif
          end
        end
      end
      LOW: begin
        if (latch) begin
          // A partial byte at the latch is an error; a frame with bytes is reported
          bit_err_d = (bit_cnt_q != 3'd0);
          if (byte_cnt_q != 6'd0) begin
            frame_done_d  = 1'b1;
            frame_bytes_d = byte_cnt_q;
          end
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 6'd0;
          state_d    = rise ? HIGH : IDLE;
`ifdef NEOPIXEL_RX_FWD_EN
          fwd_active_d = 1'b0;
`endif
        end else if (rise) begin
          state_d = HIGH;
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  // Decoder state, counters and registered outputs
  always_ff @(posedge clk_20M or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q       <= SYNC_WAIT;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= 11'd0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 6'd0;
      shift_q       <= 8'd0;
      byte_data_q   <= 8'd0;
      byte_valid_q  <= 1'b0;
      byte_index_q  <= 6'd0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= 6'd0;
      bit_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      byte_index_q  <= byte_index_d;
      frame_done_q  <= frame_done_d;
      frame_bytes_q <= frame_bytes_d;
      bit_err_q     <= bit_err_d;
    end
  end

`ifdef NEOPIXEL_RX_FWD_EN
  // Forwarding enable and the registered forwarded line
  always_ff @(posedge clk_20M or negedge rst_n_q) begin
    if (!rst_n_q) begin
      fwd_active_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      fwd_active_q <= fwd_active_d;
      dout_q       <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign byte_index  = byte_index_q;
  assign frame_done  = frame_done_q;
  assign frame_bytes = frame_bytes_q;
  assign bit_err     = bit_err_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx: self-checking bench for neopixel_rx. Table of single-byte
// frames with varied pulse widths, plus long-frame, glitch, partial-byte,
// mid-byte reset and forwarding sequences. Build with NEOPIXEL_RX_FWD_EN to
// check the forwarded line, without it to check dout stays low.
`timescale 1ns/1ps
module tb_neopixel_rx;
  import neopixel_pkg::*;

  logic       clk_20M = 1'b0;
  logic       nrst    = 1'b1;
  logic       din     = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [5:0] byte_index;
  logic       frame_done;
  logic [5:0] frame_bytes;
  logic       bit_err;
  logic       dout;

  neopixel_rx dut (
    .clk_20M     (clk_20M),
    .nrst        (nrst),
    .din         (din),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_index  (byte_index),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes),
    .bit_err     (bit_err),
    .dout        (dout)
  );

  always #25 clk_20M = ~clk_20M;

  typedef struct {
    logic [7:0] data;
    int         t0h;
    int         t1h;
    int         per;
    bit         ok;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [5:0] idx;
  } exp_byte_t;

  vec_t      vecs [8];
  exp_byte_t exp_q[$];
  int        exp_frames[$];
  int        exp_err = 0;
  int        n_checks = 0;
  int        n_fail = 0;

  // Observations, written only by the monitor
  int         cyc = 0, fall_cyc = 0, err_seen = 0, both_seen = 0;
  int         dout_hi_total = 0, dout_run = 0;
  logic       din_p = 1'b0, dout_p = 1'b0;
  logic [7:0] ob_data[$];
  logic [5:0] ob_idx[$];
  int         ob_lat[$];
  int         of_bytes[$];
  int         dout_w[$];
  int         dout_rise[$];
  int         din_rise[$];
  int         ob_rd = 0, of_rd = 0;

  initial begin
    forever begin
      @(posedge clk_20M);
      #1;
      cyc++;
      if (din && !din_p) din_rise.push_back(cyc);
      if (!din && din_p) fall_cyc = cyc;
      if (byte_valid) begin
        ob_data.push_back(byte_data);
        ob_idx.push_back(byte_index);
        ob_lat.push_back(cyc - fall_cyc + 1);
      end
      if (frame_done) of_bytes.push_back(int'(frame_bytes));
      if (bit_err) err_seen++;
      if (byte_valid && frame_done) both_seen++;
      if (dout) begin
        dout_hi_total++;
        dout_run++;
        if (!dout_p) dout_rise.push_back(cyc);
      end else if (dout_p) begin
        dout_w.push_back(dout_run);
        dout_run = 0;
      end
      din_p  = din;
      dout_p = dout;
    end
  end

  task automatic chk(input string grp, input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d", grp, nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_20M);
  endtask

  task automatic send_bit(input bit b, input int t0h, input int t1h, input int per);
    int hi;
    hi  = b ? t1h : t0h;
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    tick(per - hi);
  endtask

  task automatic send_byte(input logic [7:0] d, input int t0h, input int t1h, input int per);
    for (int i = 7; i >= 0; i--) send_bit(d[i], t0h, t1h, per);
  endtask

  task automatic send_nom(input logic [7:0] d);
    send_byte(d, T0H, T1H, T_BIT);
  endtask

  task automatic expect_byte(input logic [7:0] d, input int k);
    exp_byte_t e;
    e.data = d;
    e.idx  = (k > 63) ? 6'd63 : 6'(k);
    exp_q.push_back(e);
  endtask

  task automatic check_frame(input string grp);
    exp_byte_t e;
    int f;
    chk(grp, "byte_count", ob_data.size() - ob_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (ob_rd < ob_data.size()) begin
        chk(grp, "byte_data", int'(ob_data[ob_rd]), int'(e.data));
        chk(grp, "byte_index", int'(ob_idx[ob_rd]), int'(e.idx));
        chk(grp, "latency", ob_lat[ob_rd], 3);
        ob_rd++;
      end
    end
    ob_rd = ob_data.size();
    chk(grp, "frame_count", of_bytes.size() - of_rd, exp_frames.size());
    while (exp_frames.size() > 0) begin
      f = exp_frames.pop_front();
      if (of_rd < of_bytes.size()) begin
        chk(grp, "frame_bytes", of_bytes[of_rd], f);
        of_rd++;
      end
    end
    of_rd = of_bytes.size();
    chk(grp, "bit_err_count", err_seen, exp_err);
  endtask

  task automatic single_frame(input logic [7:0] d, input string grp);
    expect_byte(d, 0);
    exp_frames.push_back(1);
    send_nom(d);
    tick(T_LATCH);
    check_frame(grp);
  endtask

  initial begin
    int dr0, qr0, w0, hi0;
    int fw [8];
    vecs[0] = '{8'hA5, T0H, T1H, T_BIT, 1'b1};
    vecs[1] = '{8'h00, T0H, T1H, T_BIT, 1'b1};
    vecs[2] = '{8'hFF, T0H, T1H, T_BIT, 1'b1};
    vecs[3] = '{8'h5A, 3,   9,   T_BIT, 1'b1};
    vecs[4] = '{8'h0F, 8,   20,  T_BIT, 1'b1};
    vecs[5] = '{8'h33, 2,   T1H, T_BIT, 1'b0};
    vecs[6] = '{8'hC0, T0H, 21,  30,    1'b0};
    vecs[7] = '{8'h80, T0H, 35,  45,    1'b0};
    fw = '{12, 6, 6, 6, 6, 6, 6, 12};

    // Reset state
    #5 nrst = 1'b0;
    tick(3);
    chk("reset", "byte_valid", int'(byte_valid), 0);
    chk("reset", "byte_data", int'(byte_data), 0);
    chk("reset", "byte_index", int'(byte_index), 0);
    chk("reset", "frame_done", int'(frame_done), 0);
    chk("reset", "frame_bytes", int'(frame_bytes), 0);
    chk("reset", "bit_err", int'(bit_err), 0);
    chk("reset", "dout", int'(dout), 0);
    nrst = 1'b1;
    tick(1000);

    // Single-byte frames with nominal, boundary and illegal pulse widths
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].ok) begin
        expect_byte(vecs[v].data, 0);
        exp_frames.push_back(1);
      end else begin
        exp_err++;
      end
      send_byte(vecs[v].data, vecs[v].t0h, vecs[v].t1h, vecs[v].per);
      tick(T_LATCH);
      check_frame($sformatf("vec%0d", v));
    end

    // 48-byte loopback frame, byte 7 = 0xFF
    for (int k = 0; k < 48; k++) expect_byte((k == 7) ? 8'hFF : 8'h00, k);
    exp_frames.push_back(48);
    for (int k = 0; k < 48; k++) send_nom((k == 7) ? 8'hFF : 8'h00);
    tick(T_LATCH);
    check_frame("frame48");

    // 65-byte frame: index and frame_bytes saturate at 63
    for (int k = 0; k < 65; k++) expect_byte(8'(k * 5 + 1), k);
    exp_frames.push_back(63);
    for (int k = 0; k < 65; k++) send_nom(8'(k * 5 + 1));
    tick(T_LATCH);
    check_frame("frame65");

    // 2-cycle glitch mid-byte: error, rest of frame ignored, no frame_done
    expect_byte(8'h3C, 0);
    exp_err++;
    send_nom(8'h3C);
    send_bit(1'b1, T0H, T1H, T_BIT);
    send_bit(1'b0, T0H, T1H, T_BIT);
    send_bit(1'b1, T0H, T1H, T_BIT);
    send_bit(1'b0, 2, T1H, T_BIT);
    for (int i = 0; i < 4; i++) send_bit(1'b1, T0H, T1H, T_BIT);
    send_nom(8'hFF);
    tick(T_LATCH);
    check_frame("glitch");
    single_frame(8'h5A, "after_glitch");

    // 5 bits then latch: error at latch, no frame_done
    exp_err++;
    send_bit(1'b1, T0H, T1H, T_BIT);
    send_bit(1'b0, T0H, T1H, T_BIT);
    send_bit(1'b1, T0H, T1H, T_BIT);
    send_bit(1'b1, T0H, T1H, T_BIT);
    send_bit(1'b0, T0H, T1H, T_BIT);
    tick(T_LATCH);
    check_frame("partial");
    single_frame(8'h11, "after_partial");

    // Reset mid-byte: outputs clear at once, traffic before first latch ignored
    for (int i = 0; i < 4; i++) send_bit(1'b1, T0H, T1H, T_BIT);
    nrst = 1'b0;
    #1;
    chk("midreset", "byte_data", int'(byte_data), 0);
    chk("midreset", "frame_bytes", int'(frame_bytes), 0);
    chk("midreset", "byte_valid", int'(byte_valid), 0);
    chk("midreset", "bit_err", int'(bit_err), 0);
    tick(2);
    nrst = 1'b1;
    send_nom(8'hAA);
    send_nom(8'h55);
    tick(T_LATCH);
    check_frame("post_reset");
    single_frame(8'h77, "after_reset");

    // Four-byte frame for the forwarded line
    dr0 = din_rise.size();
    qr0 = dout_rise.size();
    w0  = dout_w.size();
    hi0 = dout_hi_total;
    expect_byte(8'h00, 0);
    expect_byte(8'h00, 1);
    expect_byte(8'h00, 2);
    expect_byte(8'h81, 3);
    exp_frames.push_back(4);
    send_nom(8'h00);
    send_nom(8'h00);
    send_nom(8'h00);
    send_nom(8'h81);
    tick(T_LATCH);
    check_frame("fwd");
`ifdef NEOPIXEL_RX_FWD_EN
    chk("fwd", "dout_pulses", dout_rise.size() - qr0, 8);
    if (dout_rise.size() - qr0 >= 1 && din_rise.size() - dr0 >= 25)
      chk("fwd", "dout_lag", dout_rise[qr0] - din_rise[dr0 + 24] + 1, 3);
    if (dout_w.size() - w0 >= 8)
      for (int i = 0; i < 8; i++) chk("fwd", $sformatf("width%0d", i), dout_w[w0 + i], fw[i]);
    chk("fwd", "dout_high_cycles", dout_hi_total - hi0, 60);
`else
    chk("fwd", "dout_high_cycles", dout_hi_total - hi0, 0);
`endif

    chk("all", "valid_with_done", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
